// File: rtl/packet_framer.sv
// ---------------------------------------------------------------------------
// packet_framer
//   Captures one five-byte command record on an accepted start, then sends it
//   to the USB FIFO writer as a framed byte stream:
//     STX, len, cmd, addr_lo, addr_hi, data, ETX
//   Any payload byte equal to STX, ETX or DLE is preceded by a DLE and then
//   sent unchanged. The receiving parser un-escapes the stream the same way.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   start       send request, accepted only while idle
//   len..data   payload fields, sampled on an accepted start
//   dout        stream byte
//   dout_valid  dout holds a byte to transfer
//   dout_ready  downstream can take a byte (transfer = valid & ready)
//   busy        a packet is in progress
//   done        one-cycle pulse in the first idle cycle after ETX
// ---------------------------------------------------------------------------
module packet_framer #(
   parameter logic [7:0] STX = 8'h02,
   parameter logic [7:0] ETX = 8'h03,
   parameter logic [7:0] DLE = 8'h10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] len,
   input  logic [7:0] cmd,
   input  logic [7:0] addr_lo,
   input  logic [7:0] addr_hi,
   input  logic [7:0] data,
   output logic [7:0] dout,
   output logic       dout_valid,
   input  logic       dout_ready,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SOF   = 3'd1,
      S_FIELD = 3'd2,
      S_ESC   = 3'd3,
      S_EOF   = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      idx_q, idx_d;
   logic [4:0][7:0] hold_q, hold_d;
   logic            done_q, done_d;

   logic [7:0]      cur_b;
   logic            idx_ok;
   logic            special;
   logic            xfer;

   // Current payload byte; out-of-range indices read as 0 and are caught by idx_ok.
   always_comb begin
      cur_b = 8'h00;
      case (idx_q)
         3'd0:    cur_b = hold_q[0];
         3'd1:    cur_b = hold_q[1];
         3'd2:    cur_b = hold_q[2];
         3'd3:    cur_b = hold_q[3];
         3'd4:    cur_b = hold_q[4];
         default: cur_b = 8'h00;
      endcase
   end

   assign idx_ok  = (idx_q <= 3'd4);
   assign special = (cur_b == STX) || (cur_b == ETX) || (cur_b == DLE);
   assign xfer    = dout_valid && dout_ready;
   assign busy    = (state_q != S_IDLE);
   assign done    = done_q;

   // Output decode uses registered state only, so ready/start never reach dout.
   always_comb begin
      dout       = 8'h00;
      dout_valid = 1'b0;
      case (state_q)
         S_SOF: begin
            dout       = STX;
            dout_valid = 1'b1;
         end
         S_FIELD: begin
            if (idx_ok) begin
               dout       = special ? DLE : cur_b;
               dout_valid = 1'b1;
            end
         end
         S_ESC: begin
            if (idx_ok) begin
               dout       = cur_b;
               dout_valid = 1'b1;
            end
         end
         S_EOF: begin
            dout       = ETX;
            dout_valid = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               hold_d  = {data, addr_hi, addr_lo, cmd, len};
               idx_d   = 3'd0;
               state_d = S_SOF;
            end
         end
         S_SOF: begin
            if (xfer) state_d = S_FIELD;
         end
         S_FIELD: begin
            if (!idx_ok) begin
               state_d = S_IDLE;
            end else if (xfer) begin
               if (special) begin
                  state_d = S_ESC;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = (idx_q == 3'd4) ? S_EOF : S_FIELD;
               end
            end
         end
         S_ESC: begin
            if (!idx_ok) begin
               state_d = S_IDLE;
            end else if (xfer) begin
               idx_d   = idx_q + 3'd1;
               state_d = (idx_q == 3'd4) ? S_EOF : S_FIELD;
            end
         end
         S_EOF: begin
            if (xfer) begin
               idx_d   = 3'd0;
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= 3'd0;
         hold_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_packet_framer.sv
module tb_packet_framer;

   localparam logic [7:0] STX = 8'h02;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] len, cmd, addr_lo, addr_hi, data;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ready;
   logic       busy;
   logic       done;

   packet_framer dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .len        (len),
      .cmd        (cmd),
      .addr_lo    (addr_lo),
      .addr_hi    (addr_hi),
      .data       (data),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] f[5];
      int         n;
      logic [7:0] e[12];
   } vec_t;

   vec_t       vecs[4];
   logic [7:0] sbq[$];
   int         pass_cnt = 0;
   int         total_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic rdy(input int mode, input int c);
      if (mode == 0) return 1'b1;
      if (c <= 3) return 1'b0;
      return (c % 2 == 0);
   endfunction

   // Scoreboard side: every transferred byte is popped and compared.
   logic       stall = 1'b0;
   logic [7:0] sdout = 8'h00;
   always @(negedge clk) begin
      if (reset) begin
         stall = 1'b0;
      end else begin
         if (stall) begin
            chk("hold_valid", 32'(dout_valid), 32'd1);
            chk("hold_byte", 32'(dout), 32'(sdout));
         end
         if (dout_valid && dout_ready) begin
            if (sbq.size() == 0) begin
               total_cnt++;
               $display("FAIL unexpected_byte: got %0h expected none at %0t", dout, $time);
            end else begin
               chk("stream_byte", 32'(dout), 32'(sbq.pop_front()));
            end
         end
         stall = dout_valid && !dout_ready;
         sdout = dout;
      end
   end

   task automatic set_fields(input vec_t v);
      len = v.f[0]; cmd = v.f[1]; addr_lo = v.f[2]; addr_hi = v.f[3]; data = v.f[4];
   endtask

   task automatic push_exp(input vec_t v);
      for (int i = 0; i < v.n; i++) sbq.push_back(v.e[i]);
   endtask

   task automatic run_frame(input vec_t v, input int mode, input bit disturb, input int busy_exp);
      int busy_cnt;
      bit seen;
      busy_cnt = 0;
      seen = 1'b0;
      @(posedge clk); #1;
      set_fields(v);
      start = 1'b1;
      dout_ready = 1'b1;
      push_exp(v);
      @(posedge clk); #1;
      start = 1'b0;
      chk("sof_valid", 32'(dout_valid), 32'd1);
      chk("sof_byte", 32'(dout), 32'(STX));
      for (int c = 1; c < 200; c++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) busy_cnt++;
         if (disturb) begin
            if (c == 1) begin
               len = 8'h77; cmd = 8'h66; addr_lo = 8'h55; addr_hi = 8'h44; data = 8'h33;
            end
            if (c == 3) start = 1'b1;
            if (c == 4) start = 1'b0;
         end
         dout_ready = rdy(mode, c);
         @(posedge clk); #1;
      end
      chk("done_seen", 32'(seen), 32'd1);
      chk("busy_at_done", 32'(busy), 32'd0);
      chk("sb_empty", 32'(sbq.size()), 32'd0);
      sbq.delete();
      if (busy_exp >= 0) chk("busy_cycles", 32'(busy_cnt), 32'(busy_exp));
      dout_ready = 1'b1;
      @(posedge clk); #1;
      chk("done_pulse", 32'(done), 32'd0);
   endtask

   initial begin
      int frames;
      int last_done;
      bit after_done;

      vecs[0].f = '{8'h05, 8'h01, 8'h34, 8'h12, 8'hAB};
      vecs[0].n = 7;
      vecs[0].e = '{8'h02, 8'h05, 8'h01, 8'h34, 8'h12, 8'hAB, 8'h03,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[1].f = '{8'h05, 8'h10, 8'h02, 8'h12, 8'h03};
      vecs[1].n = 10;
      vecs[1].e = '{8'h02, 8'h05, 8'h10, 8'h10, 8'h10, 8'h02, 8'h12, 8'h10,
                    8'h03, 8'h03, 8'h00, 8'h00};
      vecs[2].f = '{8'h02, 8'h03, 8'h10, 8'h10, 8'h02};
      vecs[2].n = 12;
      vecs[2].e = '{8'h02, 8'h10, 8'h02, 8'h10, 8'h03, 8'h10, 8'h10, 8'h10,
                    8'h10, 8'h10, 8'h02, 8'h03};
      vecs[3].f = '{8'hFF, 8'h00, 8'h11, 8'h0F, 8'h04};
      vecs[3].n = 7;
      vecs[3].e = '{8'h02, 8'hFF, 8'h00, 8'h11, 8'h0F, 8'h04, 8'h03,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

      reset = 1'b1;
      start = 1'b0;
      dout_ready = 1'b1;
      len = 8'h00; cmd = 8'h00; addr_lo = 8'h00; addr_hi = 8'h00; data = 8'h00;
      #2;
      chk("rst_valid", 32'(dout_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      #10 reset = 1'b0;

      // Table: plain, escaped, worst-case and no-escape frames at full rate.
      for (int i = 0; i < 4; i++) run_frame(vecs[i], 0, 1'b0, vecs[i].n);

      // Backpressure: stall STX three cycles, then alternate ready.
      run_frame(vecs[0], 1, 1'b0, -1);

      // Start and field changes while busy are ignored.
      run_frame(vecs[0], 0, 1'b1, 7);

      // Async reset between edges at the 4th byte.
      @(posedge clk); #1;
      set_fields(vecs[0]);
      start = 1'b1;
      push_exp(vecs[0]);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      chk("pre_rst_byte", 32'(dout), 32'h34);
      reset = 1'b1;
      #1;
      chk("arst_valid", 32'(dout_valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_dout", 32'(dout), 32'd0);
      sbq.delete();
      #10 reset = 1'b0;
      run_frame(vecs[0], 0, 1'b0, 7);

      // Back-to-back with start held high.
      @(posedge clk); #1;
      set_fields(vecs[0]);
      start = 1'b1;
      dout_ready = 1'b1;
      push_exp(vecs[0]);
      frames = 0;
      last_done = -1;
      after_done = 1'b0;
      for (int cyc = 1; cyc < 100; cyc++) begin
         @(posedge clk); #1;
         if (done) begin
            frames++;
            chk("b2b_idle_valid", 32'(dout_valid), 32'd0);
            chk("b2b_idle_busy", 32'(busy), 32'd0);
            if (last_done >= 0) chk("b2b_period", 32'(cyc - last_done), 32'd8);
            last_done = cyc;
            if (frames < 3) push_exp(vecs[0]);
            else start = 1'b0;
            after_done = 1'b1;
         end else if (after_done) begin
            after_done = 1'b0;
            if (frames < 3) begin
               chk("b2b_sof_valid", 32'(dout_valid), 32'd1);
               chk("b2b_sof_byte", 32'(dout), 32'(STX));
            end else begin
               chk("b2b_stop_busy", 32'(busy), 32'd0);
               break;
            end
         end
      end
      chk("b2b_frames", 32'(frames), 32'd3);
      chk("b2b_sb_empty", 32'(sbq.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/packet_framer.md
Name: packet_framer

Overview:
Parallel-to-USB packet framer. It is the transmit-side counterpart of the host-to-device packet parser. It captures one command record (len, cmd, addr_lo, addr_hi, data), then emits it as a framed byte stream: STX, five escaped payload bytes, ETX. The stream goes to the USB FIFO write interface through a valid/ready byte handshake. The framing is byte-compatible with the parser: any payload byte equal to STX, ETX or DLE is preceded by DLE and then sent unchanged.

Parameters:
STX, 8'h02, start-of-frame code
ETX, 8'h03, end-of-frame code
DLE, 8'h10, escape code

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request to send one packet; accepted only when busy=0
len  input  8  payload field 0, sampled on accepted start
cmd  input  8  payload field 1, sampled on accepted start
addr_lo  input  8  payload field 2, sampled on accepted start
addr_hi  input  8  payload field 3, sampled on accepted start
data  input  8  payload field 4, sampled on accepted start
dout  output  8  stream byte to the USB FIFO writer
dout_valid  output  1  dout holds a byte to transfer
dout_ready  input  1  downstream can accept a byte (FIFO not full)
busy  output  1  a packet is in progress (state != IDLE)
done  output  1  one-cycle pulse after ETX is transferred

Behaviour:
- Reset (async, immediate): state=IDLE, field index=0, dout=0, dout_valid=0, busy=0, done=0. Holding registers are cleared to 0.
- Transfer: a byte moves on a rising edge where dout_valid=1 and dout_ready=1.
- While dout_valid=1 and dout_ready=0, dout and the state hold unchanged.
- dout and dout_valid are decoded from registered state only. There is no combinational path from dout_ready or start to any output.
- Accept: on an edge with start=1 and state=IDLE, all five fields are copied into holding registers. Index is set to 0 and state becomes SOF.
  - start while busy=1 is ignored; no queueing.
  - Field inputs are don't-care after acceptance.
- States:
  - IDLE: dout_valid=0.
  - SOF: dout=STX, dout_valid=1. On transfer, go to FIELD.
  - FIELD: b = holding[index].
    - If b is STX, ETX or DLE: dout=DLE. On transfer, go to ESC.
    - Otherwise: dout=b. On transfer, index+1; go to EOF if index was 4, else stay in FIELD.
  - ESC: dout=holding[index] (raw, not modified). On transfer, index+1; next state as for FIELD.
  - EOF: dout=ETX. On transfer, go to IDLE and assert done for the following cycle.
- Latency: the first STX is valid in the cycle after start is accepted.
- Packet length is 7 bytes with no escapes and 12 bytes maximum. With dout_ready held high, one byte transfers per cycle.
- done and busy: done=1 in the first IDLE cycle after ETX; busy=0 in that same cycle.
  - start in that cycle is accepted, giving back-to-back packets with a one-cycle gap.
- The len field is transmitted as given; the block does not compute or check it.
- Index is 3 bits; values 5-7 are unreachable. If reached, force IDLE.
- Any undefined state encoding returns to IDLE on the next edge.

Test Plan:
1. Plain packet: len=05, cmd=01, addr_lo=34, addr_hi=12, data=AB, dout_ready=1, one start pulse. Expect 02 05 01 34 12 AB 03 on 7 consecutive cycles starting one cycle after start. done pulses once, the cycle after 03; busy is high for exactly 7 cycles.
2. Escapes: len=05, cmd=10, addr_lo=02, addr_hi=12, data=03. Expect 02 05 10 10 10 02 12 10 03 03 (10 bytes). Feeding this into the packet parser recovers 05/10/02/12/03.
3. Backpressure: same as 1, with dout_ready low for 3 cycles during STX, then alternating 1/0. Expect dout/dout_valid stable while ready=0, same 7-byte sequence with no duplicates or drops, done after the final 03.
4. Start while busy: second start with different fields mid-packet. It is ignored and the stream matches the first fields. Changing field inputs after acceptance also has no effect.
5. Async reset at the 4th byte, asserted between clock edges. dout_valid, busy and dout go to 0 immediately, without waiting for a clock edge. After release, a new start produces a complete correct 7-byte frame.
6. Back-to-back: start held high continuously with ready=1. Expect frames separated by exactly one idle cycle, and start accepted in each done cycle.
